// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: an N-deep chain of pipeline registers. Hazard logic drives
// only raw per-stage stall and flush vectors. Inside the block, holds propagate
// upstream, bubbles are inserted behind a held stage, and four saturating
// performance counters are kept.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid_i/in_data_i/in_ready_o   entry offered to stage 0
//   stall_i[k]      stage k requests hold; this freezes every upstream stage
//   flush_i[k]      stage k content is killed (beats hold)
//   clr_cnt_i       synchronous clear of all counters
//   valid_o/data_o  registered per-stage valid and payload (stage k at [k*DW +: DW])
//   retire_o        last stage hands off an entry this cycle
//   occupancy_o     number of valid stages
//   stall_cycles_o, bubble_count_o, flush_count_o, retire_count_o  saturating counters

// One stage register. Source selection (upstream copy, input, or bubble) is
// resolved in the parent; this block only applies flush/hold priority.
module pipe_stage_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
            data  <= NOP;
        end else if (!hold) begin
            valid <= src_valid;
            data  <= src_data;
        end
    end
endmodule

module pipe_stage_chain #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_STAGES = 4,
    parameter logic [31:0] NOP_VALUE  = 32'h0000_0013,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid_i,
    input  logic [DATA_WIDTH-1:0]            in_data_i,
    output logic                             in_ready_o,
    input  logic [NUM_STAGES-1:0]            stall_i,
    input  logic [NUM_STAGES-1:0]            flush_i,
    input  logic                             clr_cnt_i,
    output logic [NUM_STAGES-1:0]            valid_o,
    output logic [NUM_STAGES*DATA_WIDTH-1:0] data_o,
    output logic                             retire_o,
    output logic [$clog2(NUM_STAGES+1)-1:0]  occupancy_o,
    output logic [CNT_WIDTH-1:0]             stall_cycles_o,
    output logic [CNT_WIDTH-1:0]             bubble_count_o,
    output logic [CNT_WIDTH-1:0]             flush_count_o,
    output logic [CNT_WIDTH-1:0]             retire_count_o
);
    localparam int                    OCC_W   = $clog2(NUM_STAGES+1);
    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(NOP_VALUE);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    logic [NUM_STAGES-1:0]                 hold;
    logic [NUM_STAGES-1:0]                 bubble;
    logic [NUM_STAGES-1:0]                 src_valid;
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] src_data;
    logic [NUM_STAGES-1:0]                 stage_valid;
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] stage_data;

    // At most 8 stages, so 4 bits cover any per-cycle increment.
    function automatic logic [3:0] popcnt(input logic [NUM_STAGES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_STAGES; i++) c += 4'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [3:0]           inc);
        logic [CNT_WIDTH+3:0] s;
        s = {4'b0, c} + {{CNT_WIDTH{1'b0}}, inc};
        return (s > {4'b0, CNT_MAX}) ? CNT_MAX : s[CNT_WIDTH-1:0];
    endfunction

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Hold ripples from the output side toward stage 0.
        if (k == NUM_STAGES-1) begin : g_last
            assign hold[k] = stall_i[k];
        end else begin : g_mid
            assign hold[k] = stall_i[k] | hold[k+1];
        end

        if (k == 0) begin : g_head
            assign src_valid[k] = in_valid_i;
            assign src_data[k]  = in_valid_i ? in_data_i : NOP;
            assign bubble[k]    = 1'b0;
        end else begin : g_body
            // Upstream held while this stage moves: take a bubble.
            assign src_valid[k] = ~hold[k-1] & stage_valid[k-1];
            assign src_data[k]  = hold[k-1] ? NOP : stage_data[k-1];
            // Only bubbles that separate a real entry from its successor count.
            assign bubble[k]    = ~flush_i[k] & ~hold[k] & hold[k-1] & stage_valid[k-1];
        end

        pipe_stage_reg #(.DATA_WIDTH(DATA_WIDTH), .NOP(NOP)) u_reg (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush_i[k]),
            .hold      (hold[k]),
            .src_valid (src_valid[k]),
            .src_data  (src_data[k]),
            .valid     (stage_valid[k]),
            .data      (stage_data[k])
        );
    end

    assign valid_o     = stage_valid;
    assign data_o      = stage_data;
    assign in_ready_o  = ~hold[0];
    assign retire_o    = stage_valid[NUM_STAGES-1] & ~stall_i[NUM_STAGES-1]
                       & ~flush_i[NUM_STAGES-1];
    assign occupancy_o = OCC_W'(popcnt(stage_valid));

    always_ff @(posedge clk) begin
        if (rst || clr_cnt_i) begin
            stall_cycles_o <= '0;
            bubble_count_o <= '0;
            flush_count_o  <= '0;
            retire_count_o <= '0;
        end else begin
            stall_cycles_o <= sat_add(stall_cycles_o, 4'(|stall_i));
            bubble_count_o <= sat_add(bubble_count_o, popcnt(bubble));
            flush_count_o  <= sat_add(flush_count_o, popcnt(flush_i & stage_valid));
            retire_count_o <= sat_add(retire_count_o, 4'(retire_o));
        end
    end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (N=4, 32-bit data, 4-bit counters).
// Directed scenarios followed by a randomized phase; every cycle is compared
// against a stage-array reference model built from the operating rules.
module tb_pipe_stage_chain;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam logic [31:0] NOPV = 32'h13;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [N-1:0]  stall, flush;
    logic          clr;
    logic [N-1:0]  valid;
    logic [N*DW-1:0] data;
    logic          retire;
    logic [2:0]    occ;
    logic [CW-1:0] stall_cnt, bub_cnt, fl_cnt, ret_cnt;

    pipe_stage_chain #(.DATA_WIDTH(DW), .NUM_STAGES(N), .NOP_VALUE(NOPV), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_ready_o     (in_ready),
        .stall_i        (stall),
        .flush_i        (flush),
        .clr_cnt_i      (clr),
        .valid_o        (valid),
        .data_o         (data),
        .retire_o       (retire),
        .occupancy_o    (occ),
        .stall_cycles_o (stall_cnt),
        .bubble_count_o (bub_cnt),
        .flush_count_o  (fl_cnt),
        .retire_count_o (ret_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int peak_occ = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Reference model: one valid bit and payload per stage, plain int counters.
    bit          mv[N];
    logic [31:0] md[N];
    int          m_stall, m_bub, m_fl, m_ret;

    function automatic int sat(input int c, input int inc);
        return (c + inc > CMAX) ? CMAX : c + inc;
    endfunction

    // Stage k is frozen when any stage at or downstream of k stalls.
    function automatic bit held(input int k);
        for (int j = k; j < N; j++) if (stall[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_retire();
        return mv[N-1] && !stall[N-1] && !flush[N-1];
    endfunction

    function automatic int m_occ();
        int c = 0;
        for (int k = 0; k < N; k++) c += int'(mv[k]);
        return c;
    endfunction

    task automatic m_step();
        bit          nv[N];
        logic [31:0] nd[N];
        int bub = 0, fl = 0;
        if (rst) begin
            for (int k = 0; k < N; k++) begin mv[k] = 0; md[k] = NOPV; end
            m_stall = 0; m_bub = 0; m_fl = 0; m_ret = 0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            if (flush[k]) begin
                nv[k] = 0; nd[k] = NOPV;
                if (mv[k]) fl++;
            end else if (held(k)) begin
                nv[k] = mv[k]; nd[k] = md[k];
            end else if (k == 0) begin
                nv[k] = in_valid; nd[k] = in_valid ? in_data : NOPV;
            end else if (held(k-1)) begin
                nv[k] = 0; nd[k] = NOPV;
                if (mv[k-1]) bub++;
            end else begin
                nv[k] = mv[k-1]; nd[k] = md[k-1];
            end
        end
        if (clr) begin
            m_stall = 0; m_bub = 0; m_fl = 0; m_ret = 0;
        end else begin
            m_stall = sat(m_stall, (stall != 0) ? 1 : 0);
            m_bub   = sat(m_bub, bub);
            m_fl    = sat(m_fl, fl);
            m_ret   = sat(m_ret, m_retire() ? 1 : 0);
        end
        for (int k = 0; k < N; k++) begin mv[k] = nv[k]; md[k] = nd[k]; end
    endtask

    // One clock: combinational outputs checked at the falling edge, registered
    // state checked just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst == 1'b0) begin
            chk("in_ready", in_ready, !held(0));
            chk("retire", retire, m_retire());
            chk("occupancy", occ, m_occ());
        end
        if (int'(occ) > peak_occ) peak_occ = int'(occ);
        @(posedge clk);
        m_step();
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("valid[%0d]", k), valid[k], mv[k]);
            chk($sformatf("data[%0d]", k), data[k*DW +: DW], md[k]);
        end
        chk("stall_cycles", stall_cnt, m_stall);
        chk("bubble_count", bub_cnt, m_bub);
        chk("flush_count", fl_cnt, m_fl);
        chk("retire_count", ret_cnt, m_ret);
    endtask

    task automatic idle();
        in_valid = 0; in_data = '0; stall = '0; flush = '0; clr = 0; rst = 0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin mv[k] = 0; md[k] = NOPV; end
        m_stall = 0; m_bub = 0; m_fl = 0; m_ret = 0;

        // 1. reset with input offered
        idle(); rst = 1; in_valid = 1; in_data = 32'hDEAD;
        tick(); tick();
        idle();
        #1;
        chk("rst valid", valid, 4'b0000);
        for (int k = 0; k < N; k++) chk("rst data", data[k*DW +: DW], 32'h13);
        chk("rst counters", {stall_cnt, bub_cnt, fl_cnt, ret_cnt}, 16'h0);
        chk("rst in_ready", in_ready, 1'b1);

        // 2. stream of three entries
        peak_occ = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 32'h100 + 32'(4*i); tick();
        end
        idle(); tick();
        chk("stream s3 @4", data[3*DW +: DW], 32'h100);
        tick();
        chk("stream s3 @5", data[3*DW +: DW], 32'h104);
        tick();
        chk("stream s3 @6", data[3*DW +: DW], 32'h108);
        tick(); tick();
        chk("stream retires", ret_cnt, 4'd3);
        chk("stream peak occ", peak_occ, 3);

        // 3. fill then stall stage 1 for two cycles
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 32'hA0 + 32'(i); clr = (i == 0); tick();
        end
        idle(); stall = 4'b0010;
        tick();
        chk("stall in_ready", in_ready, 1'b0);
        tick();
        chk("stall valid", valid, 4'b0011);
        chk("stall s0", data[0*DW +: DW], 32'hA3);
        chk("stall s1", data[1*DW +: DW], 32'hA2);
        chk("stall s2 bubble", data[2*DW +: DW], 32'h13);
        chk("stall bubbles", bub_cnt, 4'd2);
        chk("stall cycles", stall_cnt, 4'd2);

        // 4. flush over stall on a full pipe
        idle();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 32'hB0 + 32'(i); clr = (i == 3); tick();
        end
        idle(); stall = 4'b0010; flush = 4'b0011;
        tick();
        idle();
        chk("flush valid", valid, 4'b1000);
        chk("flush s0", data[0*DW +: DW], 32'h13);
        chk("flush s1", data[1*DW +: DW], 32'h13);
        chk("flush s3 advanced", data[3*DW +: DW], 32'hB1);
        chk("flush count", fl_cnt, 4'd2);
        chk("flush retire", ret_cnt, 4'd1);

        // 5. saturation then clear with a concurrent stall
        clr = 1; tick(); idle();
        stall = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        chk("sat stall_cycles", stall_cnt, 4'd15);
        clr = 1; tick();
        chk("clr stall_cycles", stall_cnt, 4'd0);

        // 6. reset mid-operation with the last stage stalled
        idle();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 32'hC0 + 32'(i); clr = (i == 0); tick();
        end
        idle(); rst = 1; stall = 4'b1000;
        tick();
        chk("midrst valid", valid, 4'b0000);
        chk("midrst retire_count", ret_cnt, 4'd0);
        idle(); tick();
        chk("midrst in_ready", in_ready, 1'b1);

        // randomized phase
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(63) == 0);
            clr      = ($urandom_range(31) == 0);
            in_valid = ($urandom_range(3) != 0);
            in_data  = $urandom;
            for (int k = 0; k < N; k++) begin
                stall[k] = ($urandom_range(5) == 0);
                flush[k] = ($urandom_range(9) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
